vend_fsm: RTL and testbench

//   Parametrised, clocked vending controller generalising the coffee/soup selector to N products.

---
 rtl/vend_pkg.sv | 23 ++
 rtl/vend_fsm_if.sv | 28 ++
 rtl/vend_credit_acc.sv | 42 ++++
 rtl/vend_fsm.sv | 179 +++++++++++++++++
 tb/tb_vend_fsm.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and helpers for the vending controller
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CREDIT,
        VEND,
        CHANGE
    } vend_state_e;

    typedef enum logic [1:0] {
        ACC_HOLD,
        ACC_ADD,
        ACC_SUB,
        ACC_CLR
    } acc_op_e;

    // Base bit of product idx's price inside the packed PRICES vector.
    function automatic int price_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/vend_fsm_if.sv
// rtl/vend_fsm_if.sv - front-end / dispenser signal bundle for vend_fsm
interface vend_fsm_if #(
    parameter int N_PROD   = 2,
    parameter int CREDIT_W = 8
);
    logic                coin_valid;
    logic [CREDIT_W-1:0] coin_value;
    logic [N_PROD-1:0]   select;
    logic                cancel;
    logic                change_ack;

    logic [N_PROD-1:0]   dispense;
    logic                coin_reject;
    logic                insufficient;
    logic                change_valid;
    logic [CREDIT_W-1:0] change_amount;
    logic [CREDIT_W-1:0] credit;

    modport master (
        output coin_valid, coin_value, select, cancel, change_ack,
        input  dispense, coin_reject, insufficient, change_valid, change_amount, credit
    );

    modport slave (
        input  coin_valid, coin_value, select, cancel, change_ack,
        output dispense, coin_reject, insufficient, change_valid, change_amount, credit
    );
endinterface

// File: rtl/vend_credit_acc.sv
// rtl/vend_credit_acc.sv - credit register with overflow check and add/subtract/clear ops
module vend_credit_acc
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  acc_op_e             op,
    input  logic [CREDIT_W-1:0] add_value,
    input  logic [CREDIT_W-1:0] sub_value,
    output logic [CREDIT_W-1:0] credit,
    output logic                add_fits
);

    logic [CREDIT_W-1:0] credit_q;
    logic [CREDIT_W-1:0] credit_d;
    logic [CREDIT_W:0]   sum;

    always_comb begin
        sum      = {1'b0, credit_q} + {1'b0, add_value};
        add_fits = ~sum[CREDIT_W];
        credit_d = credit_q;
        case (op)
            ACC_ADD:  if (add_fits) credit_d = sum[CREDIT_W-1:0];
            ACC_SUB:  credit_d = credit_q - sub_value;
            ACC_CLR:  credit_d = '0;
            default:  credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end

    assign credit = credit_q;

endmodule

// File: rtl/vend_fsm.sv
// rtl/vend_fsm.sv - N-product vending controller: credit, vend, change return
// Optional inactivity auto-refund is built when VEND_TIMEOUT_EN is defined.
module vend_fsm
    import vend_pkg::*;
#(
    parameter int                          N_PROD         = 2,
    parameter int                          CREDIT_W       = 8,
    parameter logic [N_PROD*CREDIT_W-1:0]  PRICES         = {8'd3, 8'd2},
    parameter int                          TIMEOUT_CYCLES = 1000
) (
    input  logic      clk,
    input  logic      reset,
    vend_fsm_if.slave bus
);

    vend_state_e         state_q, state_d;
    logic [N_PROD-1:0]   dispense_q, dispense_d;
    logic                coin_reject_q, coin_reject_d;
    logic                insufficient_q, insufficient_d;
    logic                change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0] change_amount_q, change_amount_d;

    acc_op_e             acc_op;
    logic [CREDIT_W-1:0] credit;
    logic                add_fits;

    logic [CREDIT_W-1:0] price_arr [N_PROD];
    logic                sel_hit;
    logic [CREDIT_W-1:0] sel_price;
    logic [N_PROD-1:0]   sel_onehot;
    logic                coin_live;
    logic                timeout_fire;

    for (genvar g = 0; g < N_PROD; g++) begin : g_price
        assign price_arr[g] = PRICES[price_lsb(g, CREDIT_W) +: CREDIT_W];
    end

    // Highest pressed index with a non-zero price wins; disabled buttons are invisible.
    always_comb begin
        sel_hit    = 1'b0;
        sel_price  = '0;
        sel_onehot = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (bus.select[i] && (price_arr[i] != '0)) begin
                sel_hit       = 1'b1;
                sel_price     = price_arr[i];
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign coin_live = bus.coin_valid && (bus.coin_value != '0);

`ifdef VEND_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic             activity;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        activity     = bus.coin_valid || (bus.select != '0) || bus.cancel;
        timeout_fire = (state_q == CREDIT) && !activity && (tmo_cnt_q == TMO_LAST);
        tmo_cnt_d    = tmo_cnt_q + TMO_W'(1);
        if ((state_q != CREDIT) || activity || timeout_fire) begin
            tmo_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_fire   = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        dispense_d      = '0;
        coin_reject_d   = 1'b0;
        insufficient_d  = 1'b0;
        change_valid_d  = change_valid_q;
        change_amount_d = change_amount_q;
        acc_op          = ACC_HOLD;

        case (state_q)
            IDLE, CREDIT: begin
                // Cancel/select are judged against current credit; a coin arriving with them bounces.
                if ((state_q == CREDIT) && (bus.cancel || timeout_fire)) begin
                    state_d         = CHANGE;
                    change_valid_d  = 1'b1;
                    change_amount_d = credit;
                    coin_reject_d   = coin_live;
                end else if (sel_hit) begin
                    coin_reject_d = coin_live;
                    if (credit >= sel_price) begin
                        state_d    = VEND;
                        acc_op     = ACC_SUB;
                        dispense_d = sel_onehot;
                    end else begin
                        insufficient_d = 1'b1;
                    end
                end else if (coin_live) begin
                    if (add_fits) begin
                        acc_op  = ACC_ADD;
                        state_d = CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            VEND: begin
                coin_reject_d = coin_live;
                if (credit != '0) begin
                    state_d         = CHANGE;
                    change_valid_d  = 1'b1;
                    change_amount_d = credit;
                end else begin
                    state_d = IDLE;
                end
            end
            CHANGE: begin
                coin_reject_d = coin_live;
                if (bus.change_ack) begin
                    state_d         = IDLE;
                    acc_op          = ACC_CLR;
                    change_valid_d  = 1'b0;
                    change_amount_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            dispense_q      <= '0;
            coin_reject_q   <= 1'b0;
            insufficient_q  <= 1'b0;
            change_valid_q  <= 1'b0;
            change_amount_q <= '0;
        end else begin
            state_q         <= state_d;
            dispense_q      <= dispense_d;
            coin_reject_q   <= coin_reject_d;
            insufficient_q  <= insufficient_d;
            change_valid_q  <= change_valid_d;
            change_amount_q <= change_amount_d;
        end
    end

    vend_credit_acc #(
        .CREDIT_W (CREDIT_W)
    ) u_credit_acc (
        .clk       (clk),
        .reset     (reset),
        .op        (acc_op),
        .add_value (bus.coin_value),
        .sub_value (sel_price),
        .credit    (credit),
        .add_fits  (add_fits)
    );

    assign bus.dispense      = dispense_q;
    assign bus.coin_reject   = coin_reject_q;
    assign bus.insufficient  = insufficient_q;
    assign bus.change_valid  = change_valid_q;
    assign bus.change_amount = change_amount_q;
    assign bus.credit        = credit;

endmodule

// File: tb/tb_vend_fsm.sv
// tb/tb_vend_fsm.sv - randomized and directed check of vend_fsm against a transaction-level model
module tb_vend_fsm;

    localparam int NP  = 2;
    localparam int CW  = 8;
    localparam int TMO = 8;
    localparam logic [NP*CW-1:0] PR = {8'd3, 8'd2};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vend_fsm_if #(.N_PROD(NP), .CREDIT_W(CW)) bus ();

    vend_fsm #(
        .N_PROD         (NP),
        .CREDIT_W       (CW),
        .PRICES         (PR),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    int price_tab [NP];
    int m_credit;
    bit m_vending;
    bit m_owed;
    int m_quiet;
    int e_disp, e_rej, e_ins;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: credit is a plain integer; a vend owes a dispense pulse now, and change afterwards.
    task automatic model_step(input bit rst, input bit cv, input int val, input int sel,
                              input bit can, input bit ack);
        bit coin_live, activity, tmo;
        int pick;
        e_disp = 0;
        e_rej  = 0;
        e_ins  = 0;
        if (rst) begin
            m_credit  = 0;
            m_vending = 0;
            m_owed    = 0;
            m_quiet   = 0;
            return;
        end
        coin_live = cv && (val != 0);
        activity  = cv || (sel != 0) || can;
        tmo       = 0;
`ifdef VEND_TIMEOUT_EN
        if (!m_vending && !m_owed && (m_credit > 0) && !activity) begin
            m_quiet++;
            if (m_quiet == TMO) begin
                tmo     = 1;
                m_quiet = 0;
            end
        end else begin
            m_quiet = 0;
        end
`endif
        if (m_vending) begin
            e_rej     = coin_live;
            m_vending = 0;
            m_owed    = (m_credit > 0);
        end else if (m_owed) begin
            e_rej = coin_live;
            if (ack) begin
                m_owed   = 0;
                m_credit = 0;
            end
        end else begin
            pick = -1;
            for (int i = 0; i < NP; i++)
                if (sel[i] && (price_tab[i] != 0)) pick = i;
            if ((m_credit > 0) && (can || tmo)) begin
                m_owed = 1;
                e_rej  = coin_live;
            end else if (pick >= 0) begin
                e_rej = coin_live;
                if (m_credit >= price_tab[pick]) begin
                    m_credit  = m_credit - price_tab[pick];
                    e_disp    = 1 << pick;
                    m_vending = 1;
                end else begin
                    e_ins = 1;
                end
            end else if (coin_live) begin
                if (m_credit + val <= (1 << CW) - 1) m_credit = m_credit + val;
                else e_rej = 1;
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit cv, input int val, input int sel,
                         input bit can, input bit ack);
        reset          = rst;
        bus.coin_valid = cv;
        bus.coin_value = val[CW-1:0];
        bus.select     = sel[NP-1:0];
        bus.cancel     = can;
        bus.change_ack = ack;
        @(posedge clk);
        model_step(rst, cv, val, sel, can, ack);
        #1;
        check_eq("dispense", bus.dispense, e_disp);
        check_eq("coin_reject", bus.coin_reject, e_rej);
        check_eq("insufficient", bus.insufficient, e_ins);
        check_eq("change_valid", bus.change_valid, m_owed);
        check_eq("change_amount", bus.change_amount, m_owed ? m_credit : 0);
        check_eq("credit", bus.credit, m_credit);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic coin(input int v);
        cycle(0, 1, v, 0, 0, 0);
    endtask

    initial begin
        price_tab[0] = 2;
        price_tab[1] = 3;
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        check_eq("rst_credit", bus.credit, 0);
        check_eq("rst_change_valid", bus.change_valid, 0);

        // exact-price vend, no change
        coin(2);
        cycle(0, 0, 0, 1, 0, 0);
        check_eq("ex1_dispense", bus.dispense, 1);
        idle();
        check_eq("ex1_no_change", bus.change_valid, 0);

        // vend with change
        coin(5);
        cycle(0, 0, 0, 2, 0, 0);
        check_eq("ex2_dispense", bus.dispense, 2);
        idle();
        check_eq("ex2_change_valid", bus.change_valid, 1);
        check_eq("ex2_change_amount", bus.change_amount, 2);
        cycle(0, 0, 0, 0, 0, 1);
        check_eq("ex2_after_ack", bus.change_valid, 0);

        // insufficient then cancel, change held until ack
        coin(1);
        cycle(0, 0, 0, 3, 0, 0);
        check_eq("ex3_insufficient", bus.insufficient, 1);
        check_eq("ex3_credit", bus.credit, 1);
        cycle(0, 0, 0, 0, 1, 0);
        idle();
        idle();
        check_eq("ex3_held_amount", bus.change_amount, 1);
        cycle(0, 0, 0, 0, 0, 1);

        // overflow reject, exact fill to max, coin during change
        coin(250);
        coin(10);
        check_eq("ex4_reject", bus.coin_reject, 1);
        check_eq("ex4_credit", bus.credit, 250);
        coin(5);
        check_eq("ex4_full", bus.credit, 255);
        cycle(0, 0, 0, 0, 1, 0);
        coin(1);
        check_eq("ex4_change_reject", bus.coin_reject, 1);
        cycle(0, 0, 0, 0, 0, 1);

        // coin and select together
        coin(4);
        cycle(0, 1, 1, 1, 0, 0);
        check_eq("ex5_dispense", bus.dispense, 1);
        check_eq("ex5_reject", bus.coin_reject, 1);
        idle();
        check_eq("ex5_change", bus.change_amount, 2);
        cycle(0, 0, 0, 0, 0, 1);

        // reset while change is pending
        coin(3);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 0);
        check_eq("ex6_rst_valid", bus.change_valid, 0);
        check_eq("ex6_rst_credit", bus.credit, 0);

        // idle credit: auto-refund only with the timeout build
        coin(3);
        for (int k = 0; k < TMO - 1; k++) idle();
        check_eq("tmo_before", bus.change_valid, 0);
        idle();
`ifdef VEND_TIMEOUT_EN
        check_eq("tmo_fire_valid", bus.change_valid, 1);
        check_eq("tmo_fire_amount", bus.change_amount, 3);
        cycle(0, 0, 0, 0, 0, 1);
`else
        for (int k = 0; k < 12; k++) idle();
        check_eq("tmo_held_credit", bus.credit, 3);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 1);
`endif

        for (int n = 0; n < 4000; n++) begin
            bit r_rst, r_cv, r_can, r_ack;
            int r_val, r_sel;
            r_rst = ($urandom_range(0, 249) == 0);
            r_cv  = ($urandom_range(0, 3) == 0);
            r_val = ($urandom_range(0, 9) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 6);
            r_sel = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            r_can = ($urandom_range(0, 11) == 0);
            r_ack = ($urandom_range(0, 2) == 0);
            cycle(r_rst, r_cv, r_val, r_sel, r_can, r_ack);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
